// File: rtl/defuzzifier.sv
// Defuzzifier: computes the crisp output S_wg/S_w in Q1.15 using a
// multi-cycle restoring divider with round-to-nearest. The result is also
// given as a rounded percentage. A zero weight sum and a ratio of one or
// more skip the divider. The result is held under a valid/ready handshake.
module defuzzifier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] S_w,
    input  logic [15:0] S_wg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] y_q15,
    output logic [7:0]  y_pct,
    output logic        div_zero
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DIV   = 3'd1,
        ROUND = 3'd2,
        PCT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] Q15_MAX = 16'h7FFF;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_sw;
    logic [16:0] r_rem;
    logic [14:0] r_q;
    logic [3:0]  r_cnt;
    logic [15:0] r_y;
    logic [7:0]  r_pct;
    logic        r_dz;

    logic        w_accept;
    logic [15:0] w_sw_clamp;
    logic [15:0] w_swg_clamp;
    logic        w_is_zero;
    logic        w_is_sat;
    logic [16:0] w_rem_shift;
    logic        w_rem_ge;
    logic [17:0] w_rem_x2;
    logic        w_round_up;
    logic [15:0] w_round_sum;
    logic [22:0] w_pct_full;

    // Values with bit 15 set are outside the unsigned Q1.15 range and clamp to the maximum.
    assign w_sw_clamp  = S_w[15]  ? Q15_MAX : S_w;
    assign w_swg_clamp = S_wg[15] ? Q15_MAX : S_wg;
    assign w_accept    = in_valid && (r_state == IDLE);
    assign w_is_zero   = (w_sw_clamp == 16'd0);
    assign w_is_sat    = (w_swg_clamp >= w_sw_clamp);

    // One restoring-division step: shift, then compare against the divisor.
    assign w_rem_shift = {r_rem[15:0], 1'b0};
    assign w_rem_ge    = (w_rem_shift >= {1'b0, r_sw});

    // Round to nearest: add one when the leftover remainder is at least half the divisor.
    assign w_rem_x2    = {r_rem, 1'b0};
    assign w_round_up  = (w_rem_x2 >= {2'b00, r_sw});
    assign w_round_sum = {1'b0, r_q} + {15'd0, w_round_up};

    // The worst case 32767*100 + 16384 fits in 22 bits, so 23 bits leave headroom.
    assign w_pct_full  = ({7'd0, r_y} * 23'd100) + 23'd16384;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign y_q15     = r_y;
    assign y_pct     = r_pct;
    assign div_zero  = r_dz;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: pick the path at accept, then sequence DIV/ROUND/PCT/DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_zero)     w_state_next = DONE;
                    else if (w_is_sat) w_state_next = PCT;
                    else               w_state_next = DIV;
                end
            end
            DIV:     if (r_cnt == 4'd14) w_state_next = ROUND;
            ROUND:   w_state_next = PCT;
            PCT:     w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: capture the operands, iterate the divider, round, and scale to percent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw  <= 16'd0;
            r_rem <= 17'd0;
            r_q   <= 15'd0;
            r_cnt <= 4'd0;
            r_y   <= 16'd0;
            r_pct <= 8'd0;
            r_dz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sw  <= w_sw_clamp;
                        r_rem <= {1'b0, w_swg_clamp};
                        r_q   <= 15'd0;
                        r_cnt <= 4'd0;
                        if (w_is_zero) begin
                            r_y   <= 16'd0;
                            r_pct <= 8'd0;
                            r_dz  <= 1'b1;
                        end else if (w_is_sat) begin
                            r_y   <= Q15_MAX;
                            r_dz  <= 1'b0;
                        end else begin
                            r_dz  <= 1'b0;
                        end
                    end
                end
                DIV: begin
                    r_rem <= w_rem_ge ? (w_rem_shift - {1'b0, r_sw}) : w_rem_shift;
                    r_q   <= {r_q[13:0], w_rem_ge};
                    r_cnt <= r_cnt + 4'd1;
                end
                ROUND: begin
                    r_y <= (w_round_sum > Q15_MAX) ? Q15_MAX : w_round_sum;
                end
                PCT: begin
                    r_pct <= w_pct_full[22:15];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_defuzzifier.sv
// Testbench for defuzzifier. Stimulus pushes the expected result and the
// accept cycle into a scoreboard. A monitor pops one entry each time
// out_valid rises and checks the values and the latency.
module tb_defuzzifier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] S_w;
    logic [15:0] S_wg;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y_q15;
    logic [7:0]  y_pct;
    logic        div_zero;

    typedef struct {
        int y;
        int p;
        int dz;
        int lat;
        int acc;
    } exp_t;

    exp_t sb_q[$];
    int   total    = 0;
    int   bad      = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    bit   prev_ov  = 1'b0;

    defuzzifier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S_w       (S_w),
        .S_wg      (S_wg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_q15     (y_q15),
        .y_pct     (y_pct),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    // Monitor: compare every new result against the oldest expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", int'(y_q15), -1);
                end else begin
                    exp_t e;
                    int   lat;
                    e   = sb_q.pop_front();
                    lat = cyc - e.acc + 1;
                    $display("txn y_q15=%0d y_pct=%0d div_zero=%0d latency=%0d (exp %0d/%0d/%0d/%0d)",
                             y_q15, y_pct, div_zero, lat, e.y, e.p, e.dz, e.lat);
                    chk("y_q15", int'(y_q15), e.y);
                    chk("y_pct", int'(y_pct), e.p);
                    chk("div_zero", int'(div_zero), e.dz);
                    chk("latency", lat, e.lat);
                end
                done_cnt++;
            end
            prev_ov = out_valid;
        end
    end

    // Issue one pair, push its expectation, optionally wait for the result.
    task automatic send(input int sw, input int swg, input int ey, input int ep,
                        input int edz, input int elat, input bit wait_done);
        int   n;
        int   start_done;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        S_w      = 16'(sw);
        S_wg     = 16'(swg);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        start_done = done_cnt;
        @(posedge clk);
        #1;
        e.y = ey; e.p = ep; e.dz = edz; e.lat = elat; e.acc = cyc;
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        S_w      = 16'($urandom);
        S_wg     = 16'($urandom);
        if (wait_done) begin
            n = 0;
            while (done_cnt == start_done && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (done_cnt == start_done) chk("result_timeout", 0, 1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        S_w       = 16'd0;
        S_wg      = 16'd0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_y_q15", int'(y_q15), 0);
        chk("rst_y_pct", int'(y_pct), 0);
        chk("rst_div_zero", int'(div_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Normal path, exact and rounded quotients.
        send(16384, 8192, 16384, 50, 0, 18, 1'b1);
        send(3, 1, 10923, 33, 0, 18, 1'b1);
        send(1000, 250, 8192, 25, 0, 18, 1'b1);
        send(7, 6, 28087, 86, 0, 18, 1'b1);
        send(32767, 32766, 32767, 100, 0, 18, 1'b1);
        send(1, 0, 0, 0, 0, 18, 1'b1);
        // Saturation and zero paths.
        send(1000, 1000, 32767, 100, 0, 2, 1'b1);
        send(0, 500, 0, 0, 1, 1, 1'b1);
        send(100, 200, 32767, 100, 0, 2, 1'b1);
        // Inputs with bit 15 set clamp to 32767.
        send(16'h8000, 16'h4000, 16385, 50, 0, 18, 1'b1);
        send(16'h8000, 16'hFFFF, 32767, 100, 0, 2, 1'b1);

        // Backpressure: result held, busy inputs ignored.
        out_ready = 1'b0;
        send(1000, 250, 8192, 25, 0, 18, 1'b1);
        in_valid = 1'b1;
        S_w      = 16'd5;
        S_wg     = 16'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_y_q15", int'(y_q15), 8192);
            chk("hold_y_pct", int'(y_pct), 25);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", int'(in_ready), 1);
        chk("release_out_valid", int'(out_valid), 0);

        // Reset on edge 8, mid-division: operation abandoned.
        send(16384, 8192, 16384, 50, 0, 18, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk("middiv_in_ready", int'(in_ready), 1);
        chk("middiv_out_valid", int'(out_valid), 0);
        chk("middiv_y_q15", int'(y_q15), 0);
        chk("middiv_y_pct", int'(y_pct), 0);
        chk("middiv_div_zero", int'(div_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        send(16384, 8192, 16384, 50, 0, 18, 1'b1);

        repeat (30) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
